// File: rtl/instr_sequencer.sv
// Fetch/issue controller: walks instruction memory and issues each decoded word to one
// processor over a one-hot req/ack handshake, strictly one request at a time.
module instr_sequencer #(
    parameter int NUM_INSTR = 11,
    parameter int NUM_PROC  = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic                start_i,
    output logic [7:0]          endereco_o,
    input  logic [15:0]         instr_i,
    output logic [NUM_PROC-1:0] proc_req_o,
    output logic                write_read_o,
    output logic [4:0]          tag_o,
    output logic [6:0]          dado_o,
    input  logic [NUM_PROC-1:0] proc_ack_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [7:0]          issued_cnt_o,
    output logic [7:0]          skip_cnt_o,
    output logic                timeout_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int              CW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [7:0]      PC_LAST    = 8'(NUM_INSTR - 1);
    localparam logic [3:0]      PROC_LIMIT = 4'(NUM_PROC);

    state_t                state_q, state_d;
    logic [7:0]            pc_q, pc_d;
    logic [NUM_PROC-1:0]   req_q, req_d;
    logic                  wr_q, wr_d;
    logic [4:0]            tag_q, tag_d;
    logic [6:0]            dado_q, dado_d;
    logic [7:0]            issued_q, issued_d;
    logic [7:0]            skip_q, skip_d;
    logic                  terr_q, terr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ack_hit;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // req_q is one-hot on the target, so masking with it ignores acks from other processors
    assign ack_hit = |(proc_ack_i & req_q);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            req_q    <= '0;
            wr_q     <= 1'b0;
            tag_q    <= '0;
            dado_q   <= '0;
            issued_q <= '0;
            skip_q   <= '0;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            tag_q    <= tag_d;
            dado_q   <= dado_d;
            issued_q <= issued_d;
            skip_q   <= skip_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        wr_d     = wr_q;
        tag_d    = tag_q;
        dado_d   = dado_q;
        issued_d = issued_q;
        skip_d   = skip_q;
        terr_d   = terr_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d  = S_FETCH;
                    pc_d     = '0;
                    issued_d = '0;
                    skip_d   = '0;
                    terr_d   = 1'b0;
                end
            end
            S_FETCH: begin
                wr_d   = instr_i[12];
                tag_d  = instr_i[11:7];
                dado_d = instr_i[6:0];
                cnt_d  = '0;
                if ({1'b0, instr_i[15:13]} >= PROC_LIMIT) begin
                    skip_d  = sat_inc(skip_q);
                    state_d = S_NEXT;
                end else begin
                    req_d   = NUM_PROC'(1) << instr_i[15:13];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ack_hit) begin
                    req_d    = '0;
                    issued_d = sat_inc(issued_q);
                    state_d  = S_NEXT;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = '0;
                    skip_d  = sat_inc(skip_q);
                    terr_d  = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_NEXT: begin
                if (pc_q == PC_LAST) begin
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_FETCH, S_ISSUE, S_NEXT: busy_o = 1'b1;
            S_DONE:                   done_o = 1'b1;
            default:                  ;
        endcase
    end

    assign endereco_o    = pc_q;
    assign proc_req_o    = req_q;
    assign write_read_o  = wr_q;
    assign tag_o         = tag_q;
    assign dado_o        = dado_q;
    assign issued_cnt_o  = issued_q;
    assign skip_cnt_o    = skip_q;
    assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: instruction memory model, ack responder and
// request-pulse monitor, with per-scenario tasks checking hand-computed values.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  endereco;
    logic [15:0] instr;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic        wr;
    logic [4:0]  tag;
    logic [6:0]  dado;
    logic        busy, done;
    logic [7:0]  issued, skip;
    logic        terr;

    logic [15:0] mem [0:255];
    int          dly [0:255];
    bit          ack_en = 1'b1;
    int          hold;

    int          pulse_n;
    logic [7:0]  p_addr [0:31];
    logic [3:0]  p_req  [0:31];
    int          p_w    [0:31];
    logic [3:0]  prev_req = '0;
    bit          multi_hot = 1'b0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign instr = mem[endereco];

    instr_sequencer #(.NUM_INSTR(11), .NUM_PROC(4), .TIMEOUT(8)) dut (
        .clock_i      (clk),
        .reset_ni     (rst_n),
        .start_i      (start),
        .endereco_o   (endereco),
        .instr_i      (instr),
        .proc_req_o   (req),
        .write_read_o (wr),
        .tag_o        (tag),
        .dado_o       (dado),
        .proc_ack_i   (ack),
        .busy_o       (busy),
        .done_o       (done),
        .issued_cnt_o (issued),
        .skip_cnt_o   (skip),
        .timeout_err_o(terr)
    );

    // Ack responder: acks the target after dly[addr]+1 cycles of request.
    initial begin
        ack  = '0;
        hold = 0;
        forever begin
            @(negedge clk);
            if (ack_en) begin
                if (req != 4'b0000) begin
                    ack = (hold == dly[endereco]) ? req : 4'b0000;
                    hold++;
                end else begin
                    ack  = '0;
                    hold = 0;
                end
            end
        end
    end

    // Request monitor: records address, target and width of every request pulse.
    initial begin
        pulse_n = 0;
        forever begin
            @(negedge clk);
            if ($countones(req) > 1) multi_hot = 1'b1;
            if (req != 4'b0000) begin
                if (prev_req == 4'b0000 && pulse_n < 32) begin
                    p_addr[pulse_n] = endereco;
                    p_req[pulse_n]  = req;
                    p_w[pulse_n]    = 1;
                    pulse_n++;
                end else if (pulse_n > 0) begin
                    p_w[pulse_n-1]++;
                end
            end
            prev_req = req;
        end
    end

    function automatic logic [3:0] exp_req(input logic [7:0] a);
        logic [15:0] w;
        w = mem[a];
        return 4'b0001 << w[15:13];
    endfunction

    task automatic clear_mon();
        pulse_n = 0;
        for (int i = 0; i < 32; i++) begin
            p_addr[i] = 8'hFF;
            p_req[i]  = 4'b0000;
            p_w[i]    = 0;
        end
    endtask

    task automatic set_delays(input int d);
        for (int i = 0; i < 256; i++) dly[i] = d;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) $display("FAIL %s_done_wait done=%b expected 1", nm, done);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({endereco, req, wr, tag, dado, busy, done, issued, skip, terr} !== '0)
            $display("FAIL reset_outputs got addr=%0d req=%b wr=%b tag=%0d dado=%0d busy=%b done=%b iss=%0d skip=%0d terr=%b expected all 0",
                     endereco, req, wr, tag, dado, busy, done, issued, skip, terr);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req !== 4'b0000) $display("FAIL reset_idle busy=%b req=%b expected 0/0000", busy, req);
        else passed++;
    endtask

    // Words 0 and 1: first-cycle ack on P0, then five-cycle hold on P3; run continues to done.
    task automatic test_first_words();
        clear_mon();
        set_delays(1);
        dly[0] = 0;
        dly[1] = 4;
        do_start();
        checks++;
        if (busy !== 1'b1 || endereco !== 8'd0 || req !== 4'b0000)
            $display("FAIL t1_fetch busy=%b addr=%0d req=%b expected 1/0/0000", busy, endereco, req);
        else passed++;
        @(negedge clk);
        checks++;
        if (req !== 4'b0001 || wr !== 1'b0 || tag !== 5'd20 || dado !== 7'd0)
            $display("FAIL t1_issue req=%b wr=%b tag=%0d dado=%0d expected 0001/0/20/0", req, wr, tag, dado);
        else passed++;
        @(negedge clk);
        checks++;
        if (req !== 4'b0000 || issued !== 8'd1) $display("FAIL t1_ack req=%b iss=%0d expected 0000/1", req, issued);
        else passed++;
        @(negedge clk);
        checks++;
        if (endereco !== 8'd1 || req !== 4'b0000) $display("FAIL t1_advance addr=%0d req=%b expected 1/0000", endereco, req);
        else passed++;
        @(negedge clk);
        checks++;
        if (req !== 4'b1000 || wr !== 1'b1 || tag !== 5'd10 || dado !== 7'd30)
            $display("FAIL t2_issue req=%b wr=%b tag=%0d dado=%0d expected 1000/1/10/30", req, wr, tag, dado);
        else passed++;
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (req !== 4'b1000 || wr !== 1'b1 || tag !== 5'd10 || dado !== 7'd30)
                $display("FAIL t2_hold[%0d] req=%b wr=%b tag=%0d dado=%0d expected 1000/1/10/30", c, req, wr, tag, dado);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (req !== 4'b0000 || issued !== 8'd2) $display("FAIL t2_ack req=%b iss=%0d expected 0000/2", req, issued);
        else passed++;
        wait_done("t2");
        checks++;
        if (issued !== 8'd11 || skip !== 8'd0 || busy !== 1'b0 || req !== 4'b0000)
            $display("FAIL t2_final iss=%0d skip=%0d busy=%b req=%b expected 11/0/0/0000", issued, skip, busy, req);
        else passed++;
        checks++;
        if (pulse_n !== 11 || p_w[0] !== 1 || p_w[1] !== 5)
            $display("FAIL t2_pulses n=%0d w0=%0d w1=%0d expected 11/1/5", pulse_n, p_w[0], p_w[1]);
        else passed++;
    endtask

    // Restart from DONE, every ack after 2 cycles, stray start mid-run.
    task automatic test_full_program();
        int n;
        clear_mon();
        set_delays(1);
        do_start();
        checks++;
        if (endereco !== 8'd0 || done !== 1'b0 || busy !== 1'b1 || issued !== 8'd0)
            $display("FAIL t3_restart addr=%0d done=%b busy=%b iss=%0d expected 0/0/1/0", endereco, done, busy, issued);
        else passed++;
        n = 0;
        while (pulse_n < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pulse_n < 5) $display("FAIL t3_progress pulses=%0d expected >=5", pulse_n);
        else passed++;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t3");
        checks++;
        if (issued !== 8'd11 || skip !== 8'd0 || terr !== 1'b0 || pulse_n !== 11)
            $display("FAIL t3_counts iss=%0d skip=%0d terr=%b pulses=%0d expected 11/0/0/11", issued, skip, terr, pulse_n);
        else passed++;
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (p_addr[k] !== 8'(k) || p_req[k] !== exp_req(8'(k)) || p_w[k] !== 2)
                $display("FAIL t3_order[%0d] addr=%0d req=%b w=%0d expected %0d/%b/2", k, p_addr[k], p_req[k], p_w[k], k, exp_req(8'(k)));
            else passed++;
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        set_delays(1);
        dly[2] = 1000;
        do_start();
        wait_done("t4");
        checks++;
        if (terr !== 1'b1 || skip !== 8'd1 || issued !== 8'd10)
            $display("FAIL t4_counts terr=%b skip=%0d iss=%0d expected 1/1/10", terr, skip, issued);
        else passed++;
        checks++;
        if (pulse_n !== 11 || p_addr[2] !== 8'd2 || p_w[2] !== 8)
            $display("FAIL t4_drop pulses=%0d addr2=%0d w2=%0d expected 11/2/8", pulse_n, p_addr[2], p_w[2]);
        else passed++;
        checks++;
        if (p_addr[3] !== 8'd3 || p_req[3] !== exp_req(8'd3))
            $display("FAIL t4_next addr=%0d req=%b expected 3/%b", p_addr[3], p_req[3], exp_req(8'd3));
        else passed++;
    endtask

    // Word 4 targets processor 5 (absent); wrong-bit acks on word 0 must not advance.
    task automatic test_skip_and_wrong_ack();
        int e;
        mem[4] = 16'hA000;
        clear_mon();
        set_delays(1);
        ack_en = 1'b0;
        ack    = 4'b0000;
        do_start();
        @(negedge clk);
        checks++;
        if (req !== 4'b0001) $display("FAIL t5_req req=%b expected 0001", req);
        else passed++;
        ack = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req !== 4'b0001 || endereco !== 8'd0 || issued !== 8'd0)
                $display("FAIL t5_wrong_ack[%0d] req=%b addr=%0d iss=%0d expected 0001/0/0", c, req, endereco, issued);
            else passed++;
        end
        ack = 4'b0001;
        @(negedge clk);
        ack    = 4'b0000;
        ack_en = 1'b1;
        checks++;
        if (req !== 4'b0000 || issued !== 8'd1) $display("FAIL t5_right_ack req=%b iss=%0d expected 0000/1", req, issued);
        else passed++;
        wait_done("t5");
        checks++;
        if (skip !== 8'd1 || issued !== 8'd10 || terr !== 1'b0 || pulse_n !== 10)
            $display("FAIL t5_counts skip=%0d iss=%0d terr=%b pulses=%0d expected 1/10/0/10", skip, issued, terr, pulse_n);
        else passed++;
        for (int k = 0; k < 10; k++) begin
            e = (k < 4) ? k : k + 1;
            checks++;
            if (p_addr[k] !== 8'(e) || p_req[k] !== exp_req(8'(e)))
                $display("FAIL t5_order[%0d] addr=%0d req=%b expected %0d/%b", k, p_addr[k], p_req[k], e, exp_req(8'(e)));
            else passed++;
        end
        mem[4] = 16'h1FFF;
    endtask

    task automatic test_reset_mid_issue();
        clear_mon();
        set_delays(1);
        dly[0] = 1000;
        do_start();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req !== 4'b0001 || busy !== 1'b1) $display("FAIL t6_pre req=%b busy=%b expected 0001/1", req, busy);
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (req !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || endereco !== 8'd0)
            $display("FAIL t6_async req=%b busy=%b done=%b addr=%0d expected 0000/0/0/0", req, busy, done, endereco);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req !== 4'b0000 || done !== 1'b0)
            $display("FAIL t6_idle busy=%b req=%b done=%b expected 0/0000/0", busy, req, done);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]  = 16'h0A00;
        mem[1]  = 16'h751E;
        mem[2]  = 16'h3085;
        mem[3]  = 16'h4123;
        mem[4]  = 16'h1FFF;
        mem[5]  = 16'h2000;
        mem[6]  = 16'h6000;
        mem[7]  = 16'h4000;
        mem[8]  = 16'h0001;
        mem[9]  = 16'h7F7F;
        mem[10] = 16'h3333;
        set_delays(1);
        clear_mon();

        test_reset();
        test_first_words();
        test_full_program();
        test_timeout();
        test_skip_and_wrong_ack();
        test_reset_mid_issue();

        checks++;
        if (multi_hot) $display("FAIL one_hot multi_hot=%b expected 0", multi_hot);
        else passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
